keypad_scan_ctrl: RTL and testbench
===================================

Name: keypad_scan_ctrl

Overview:
Scan controller for the 4x4 active-low matrix keypad. It drives the row lines one at a time and samples the column lines. It debounces the press and the release, then emits a 4-bit key code with a single-cycle valid strobe. It sits between the keypad pins and the input-capture logic, and replaces free-running row drive plus level-based decoding.

Parameters:
SCAN_DIV, 1000, clk cycles each row stays driven (dwell); column sample taken on the last dwell cycle; minimum 2
DEBOUNCE_CNT, 8, consecutive identical samples needed to accept a press or a release; minimum 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
col_n  in  4  keypad columns, active low, asynchronous to clk
row_n  out  4  row drive, one-hot low
key_code  out  4  code of the last accepted key
key_valid  out  1  one-cycle strobe when a new key is accepted
key_held  out  1  high while the accepted key is still down (PRESSED and RELEASE states)

Behaviour:
- Reset values: row_n=4'b1110, key_code=0, key_valid=0, key_held=0, state=SCAN, dwell counter=0, debounce counter=0, synchronizer=4'b1111.
- col_n passes through a 2-flop synchronizer, which adds 2 cycles of latency. All decisions use the synchronized value.
- Dwell counter runs 0..SCAN_DIV-1. A "sample" is the synchronized column value at count SCAN_DIV-1. The counter wraps to 0 after each sample.
- A sample is valid only when exactly one bit is low (1110, 1101, 1011 or 0111). 1111 means idle. Any pattern with more than one bit low is invalid and treated as idle in SCAN.
- SCAN:
  - Valid sample: latch the column pattern, set debounce counter=1, go to DEBOUNCE. The row does not advance.
  - Otherwise: rotate row_n left through 1110 -> 1101 -> 1011 -> 0111 -> 1110.
- DEBOUNCE (row frozen):
  - Sample equals the latched pattern: increment the counter.
  - Counter reaches DEBOUNCE_CNT: go to PRESSED. In the cycle after that sample, key_code is updated and key_valid=1 for exactly 1 cycle.
  - Sample differs from the latched pattern: go to SCAN and advance the row. No strobe.
- PRESSED (row frozen, key_held=1):
  - Sample 1111: counter=1, go to RELEASE.
  - Any other sample, including a different key: stay in PRESSED. No new strobe; rollover is not supported.
- RELEASE (key_held=1):
  - Sample 1111: increment the counter. At DEBOUNCE_CNT, go to SCAN, advance the row, and deassert key_held.
  - Any other sample: return to PRESSED. No strobe.
- With DEBOUNCE_CNT=1, acceptance happens on the first matching sample.
- Decode, (row_n, col_n) -> code:
  - row 1110: cols 1110/1101/1011/0111 -> 1, 2, 3, 10
  - row 1101: -> 4, 5, 6, 11
  - row 1011: -> 7, 8, 9, 12
  - row 0111: -> 14, 0, 15, 13
- key_code holds its value between presses. Only an accepted press changes it.
- Reset asserted mid-operation forces all reset values immediately, including when key_valid is high. After reset, a key still held is re-detected and strobes once.
- The debounce counter saturates and never wraps.

Decomposition:
- keypad_pkg holds:
  - state enum {SCAN, DEBOUNCE, PRESSED, RELEASE}
  - constants ROW_INIT=4'b1110 and COL_IDLE=4'b1111
  - function key_decode(row_n, col_n) returning the 4-bit code
  - function onehot_low(col) returning the validity flag
- One sub-module, keypad_col_sync: 4-bit 2-flop synchronizer with async reset to 1111.
- FSM and counters stay in keypad_scan_ctrl.

Test Plan:
1. Idle, col_n=1111, with SCAN_DIV=4: row_n cycles 1110, 1101, 1011, 0111 and changes every 4 cycles; key_valid stays 0.
2. Key 5 (col 1101 low while row 1101 is driven) held for 20 samples, DEBOUNCE_CNT=3: exactly one key_valid pulse with key_code=5, key_held=1 until 3 idle samples after release, then scanning resumes.
3. Bounce: col 1110 toggles against 1111 on alternate samples while row 0111 is driven: no strobe, key_code unchanged, scan continues.
4. Two columns low (0011) on row 1110: treated as idle, no strobe, rows keep rotating.
5. Press D (row 0111, col 0111), release for 1 sample, press again, release fully: one strobe with key_code=13, key_held stays 1 across the short release glitch.
6. rst asserted during PRESSED: row_n=1110, key_held=0, key_code=0 immediately; with the key still held after rst drops, exactly one new strobe with the correct code.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, constants and decode helpers for the keypad scanner
// Purpose: FSM state encoding, idle/initial line patterns, key decode table and
//          the single-key validity test used by keypad_scan_ctrl.
// Ports:   none (package)
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  localparam logic [3:0] ROW_INIT = 4'b1110;
  localparam logic [3:0] COL_IDLE = 4'b1111;

  // True only when exactly one column line is pulled low.
  function automatic logic onehot_low(input logic [3:0] col);
    return (col == 4'b1110) || (col == 4'b1101) ||
           (col == 4'b1011) || (col == 4'b0111);
  endfunction

  // Each row packs its four codes as {col3, col2, col1, col0}.
  function automatic logic [3:0] key_decode(input logic [3:0] row_n,
                                            input logic [3:0] col_n);
    logic [1:0]  c;
    logic [15:0] tbl;
    case (col_n)
      4'b1110: c = 2'd0;
      4'b1101: c = 2'd1;
      4'b1011: c = 2'd2;
      default: c = 2'd3;
    endcase
    case (row_n)
      4'b1110: tbl = 16'hA321;
      4'b1101: tbl = 16'hB654;
      4'b1011: tbl = 16'hC987;
      default: tbl = 16'hDF0E;
    endcase
    return tbl[{c, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// rtl/keypad_col_sync.sv - two-flop synchronizer for the keypad column lines
// Purpose: bring the asynchronous col_n lines into the clk domain.
// Ports:   clk    in  system clock
//          rst    in  asynchronous active-high reset (outputs go idle, 1111)
//          d      in  raw column lines
//          q      out synchronized column lines (2 cycles latency)
module keypad_col_sync
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= COL_IDLE;
      q    <= COL_IDLE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 active-low keypad scanner with press/release debounce
// Purpose: drives one row low at a time, samples the synchronized columns once
//          per dwell period, debounces press and release, and strobes the key code.
// Ports:   clk        in  system clock
//          rst        in  asynchronous active-high reset
//          col_n[3:0] in  keypad columns, active low, asynchronous
//          row_n[3:0] out row drive, one-hot low
//          key_code   out code of the last accepted key
//          key_valid  out one-cycle strobe on a newly accepted key
//          key_held   out high while the accepted key is still down
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int             DW         = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam int             CW         = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0]  DEB_TARGET = CW'(DEBOUNCE_CNT);
  localparam logic [CW-1:0]  DEB_ONE    = CW'(1);
  // With a single-sample debounce the first valid sample is already accepted.
  localparam logic           SINGLE     = (DEBOUNCE_CNT == 1);

  kp_state_t     state, state_nxt;
  logic [3:0]    col_s;
  logic [3:0]    col_lat;
  logic [DW-1:0] dwell_cnt;
  logic [CW-1:0] deb_cnt;

  logic       tick, smp_valid, smp_idle, smp_match, deb_reach;
  logic       accept, row_adv, deb_load, deb_inc, latch;
  logic [3:0] accept_col;

  keypad_col_sync u_col_sync (
    .clk (clk),
    .rst (rst),
    .d   (col_n),
    .q   (col_s)
  );

  assign tick      = (dwell_cnt == DWELL_LAST);
  assign smp_valid = onehot_low(col_s);
  assign smp_idle  = (col_s == COL_IDLE);
  assign smp_match = (col_s == col_lat);
  // The sample being processed now is the one that brings the count to target.
  assign deb_reach = (deb_cnt >= (DEB_TARGET - DEB_ONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SCAN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (tick) begin
      case (state)
        SCAN:     if (smp_valid) state_nxt = SINGLE ? PRESSED : DEBOUNCE;
        DEBOUNCE: state_nxt = smp_match ? (deb_reach ? PRESSED : DEBOUNCE) : SCAN;
        PRESSED:  if (smp_idle) state_nxt = SINGLE ? SCAN : RELEASE;
        RELEASE:  state_nxt = smp_idle ? (deb_reach ? SCAN : RELEASE) : PRESSED;
        default:  state_nxt = SCAN;
      endcase
    end
  end

  always_comb begin
    key_held   = (state == PRESSED) || (state == RELEASE);
    accept     = 1'b0;
    row_adv    = 1'b0;
    deb_load   = 1'b0;
    deb_inc    = 1'b0;
    latch      = 1'b0;
    accept_col = col_lat;
    if (tick) begin
      case (state)
        SCAN: begin
          if (smp_valid) begin
            latch      = 1'b1;
            deb_load   = 1'b1;
            accept     = SINGLE;
            accept_col = col_s;
          end else begin
            row_adv = 1'b1;
          end
        end
        DEBOUNCE: begin
          if (smp_match) begin
            deb_inc = 1'b1;
            accept  = deb_reach;
          end else begin
            row_adv = 1'b1;
          end
        end
        PRESSED: begin
          if (smp_idle) begin
            deb_load = 1'b1;
            row_adv  = SINGLE;
          end
        end
        RELEASE: begin
          if (smp_idle) begin
            deb_inc = 1'b1;
            row_adv = deb_reach;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_cnt <= '0;
      deb_cnt   <= '0;
      row_n     <= ROW_INIT;
      col_lat   <= COL_IDLE;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
    end else begin
      dwell_cnt <= tick ? '0 : dwell_cnt + 1'b1;
      key_valid <= accept;
      if (accept)  key_code <= key_decode(row_n, accept_col);
      if (row_adv) row_n    <= {row_n[2:0], row_n[3]};
      if (latch)   col_lat  <= col_s;
      if (deb_load)
        deb_cnt <= DEB_ONE;
      else if (deb_inc && (deb_cnt < DEB_TARGET))
        deb_cnt <= deb_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - directed self-checking bench for keypad_scan_ctrl
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic       key_en;
  logic [1:0] key_r;
  logic [3:0] key_pat;

  int n_vec = 0;
  int n_bad = 0;

  int         strobes = 0;
  logic [3:0] last_code = 4'd0;
  int         row_hits [4] = '{0, 0, 0, 0};
  int         held_low = 0;

  always #5 clk = ~clk;

  // Keypad model: the pressed key shorts its row to the column pattern.
  always_comb col_n = (key_en && (row_n[key_r] == 1'b0)) ? key_pat : 4'b1111;

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always @(negedge clk) begin
    if (key_valid) begin
      strobes   = strobes + 1;
      last_code = key_code;
    end
    for (int j = 0; j < 4; j++) if (!row_n[j]) row_hits[j] = row_hits[j] + 1;
    if (!key_held) held_low = held_low + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe(input int s0, input int budget);
    int i;
    i = 0;
    while (strobes == s0 && i < budget) begin
      @(negedge clk);
      i++;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int         s0, s1;
  int         hits0 [4];
  int         hl0;
  logic [3:0] e, m;

  initial begin
    rst = 1'b1; key_en = 1'b0; key_r = 2'd0; key_pat = 4'b1111;
    cycles(3);
    chk("rst_row", row_n, 4'b1110);
    chk("rst_code", key_code, 4'd0);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_held", key_held, 1'b0);
    rst = 1'b0;

    // 1: idle scan, row changes every 4 cycles
    s0 = strobes;
    for (int i = 1; i <= 16; i++) begin
      cycles(1);
      if ((i % 4) == 3 || (i % 4) == 0) begin
        e = 4'b1110;
        repeat (i / 4) e = {e[2:0], e[3]};
        chk($sformatf("t1_row_%0d", i), row_n, e);
      end
    end
    chk("t1_nostrobe", strobes - s0, 0);

    // 2: key 5 held, then released
    s0 = strobes;
    key_r = 2'd1; key_pat = 4'b1101; key_en = 1'b1;
    wait_strobe(s0, 200);
    chk("t2_code", last_code, 4'd5);
    cycles(1);
    chk("t2_held", key_held, 1'b1);
    cycles(80);
    chk("t2_one_strobe", strobes - s0, 1);
    chk("t2_held_long", key_held, 1'b1);
    key_en = 1'b0;
    cycles(4);
    chk("t2_held_early_release", key_held, 1'b1);
    cycles(12);
    chk("t2_released", key_held, 1'b0);
    for (int j = 0; j < 4; j++) hits0[j] = row_hits[j];
    cycles(32);
    for (int j = 0; j < 4; j++) m[j] = (row_hits[j] > hits0[j]);
    chk("t2_rescan", m, 4'hF);

    // 3: bouncing key on row 0111
    s0 = strobes;
    for (int j = 0; j < 4; j++) hits0[j] = row_hits[j];
    key_r = 2'd3; key_pat = 4'b1110; key_en = 1'b0;
    for (int i = 0; i < 30; i++) begin
      key_en = ~key_en;
      cycles(4);
    end
    key_en = 1'b0;
    for (int j = 0; j < 4; j++) m[j] = (row_hits[j] > hits0[j]);
    chk("t3_nostrobe", strobes - s0, 0);
    chk("t3_code_kept", key_code, 4'd5);
    chk("t3_rows", m, 4'hF);

    // 4: two columns low on row 1110
    s0 = strobes;
    for (int j = 0; j < 4; j++) hits0[j] = row_hits[j];
    key_r = 2'd0; key_pat = 4'b0011; key_en = 1'b1;
    cycles(100);
    for (int j = 0; j < 4; j++) m[j] = (row_hits[j] > hits0[j]);
    chk("t4_nostrobe", strobes - s0, 0);
    chk("t4_rows", m, 4'hF);
    chk("t4_held", key_held, 1'b0);
    key_en = 1'b0;
    cycles(8);

    // 5: key D with a one-sample release glitch
    s0 = strobes;
    key_r = 2'd3; key_pat = 4'b0111; key_en = 1'b1;
    wait_strobe(s0, 200);
    chk("t5_code", last_code, 4'd13);
    cycles(20);
    hl0 = held_low;
    key_en = 1'b0;
    cycles(4);
    key_en = 1'b1;
    cycles(40);
    chk("t5_held_through_glitch", held_low - hl0, 0);
    key_en = 1'b0;
    cycles(20);
    chk("t5_released", key_held, 1'b0);
    chk("t5_one_strobe", strobes - s0, 1);

    // 6: reset while the strobe is high, key still held afterwards
    s0 = strobes;
    key_r = 2'd2; key_pat = 4'b1011; key_en = 1'b1;
    for (int i = 0; i < 200 && !key_valid; i++) cycles(1);
    chk("t6_valid_seen", key_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_rst_row", row_n, 4'b1110);
    chk("t6_rst_held", key_held, 1'b0);
    chk("t6_rst_code", key_code, 4'd0);
    chk("t6_rst_valid", key_valid, 1'b0);
    cycles(3);
    s1 = strobes;
    chk("t6_killed_strobe", s1 - s0, 0);
    rst = 1'b0;
    wait_strobe(s1, 200);
    chk("t6_code", last_code, 4'd9);
    cycles(40);
    chk("t6_one_strobe", strobes - s1, 1);
    chk("t6_held", key_held, 1'b1);
    key_en = 1'b0;
    cycles(20);
    chk("t6_released", key_held, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
